// File: rtl/hash_stream_pkg.sv
// hash_stream_pkg: shared widths, default timing and FSM states for the hash message streamer
package hash_stream_pkg;
  localparam int LEN_W = 64;
  localparam int BYTE_W = 8;
  localparam int DIG_W = 32;
  localparam int MIN_LAT_DEF = 2;
  localparam int TIMEOUT_DEF = 64;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, OUT} state_t;
endpackage

// File: rtl/hash_msg_streamer_byte_fifo.sv
// byte_fifo: synchronous byte FIFO with fall-through read; pushes are refused while full
module byte_fifo
  import hash_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/hash_msg_streamer.sv
// hash_msg_streamer: feeds a length command and buffered bytes into the hash core,
// then returns the digest (or a timeout error) on a valid/ready result port
module hash_msg_streamer
  import hash_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_LAT = MIN_LAT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              M_valid,
  output logic [LEN_W-1:0]  C_in,
  output logic [BYTE_W-1:0] M,
  input  logic              hash_ready,
  input  logic [DIG_W-1:0]  digest_final,
  output logic              dig_valid,
  input  logic              dig_ready,
  output logic [DIG_W-1:0]  dig_data,
  output logic              dig_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [LEN_W-1:0] rem, rem_n, c_in_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic [BYTE_W-1:0] m_n, fifo_q;
  logic [DIG_W-1:0] dig_data_n;
  logic m_valid_n, dig_err_n, pop, full, empty;
  assign cmd_ready = state == IDLE;
  assign in_ready = !full;
  assign dig_valid = state == OUT;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (in_valid),
    .din  (in_data),
    .pop  (pop),
    .dout (fifo_q),
    .full (full),
    .empty(empty)
  );
  always_comb begin
    state_n = state;
    rem_n = rem;
    c_in_n = C_in;
    wcnt_n = wcnt;
    m_n = M;
    m_valid_n = 1'b0;
    dig_data_n = dig_data;
    dig_err_n = dig_err;
    pop = 1'b0;
    case (state)
      IDLE:
        if (cmd_valid) begin
          c_in_n = cmd_len;
          rem_n = cmd_len;
          // an empty message still needs one start strobe with no byte behind it
          if (cmd_len == '0) begin
            m_valid_n = 1'b1;
            m_n = '0;
            wcnt_n = '0;
            state_n = WAIT;
          end else begin
            state_n = SEND;
          end
        end
      SEND:
        if (!empty && rem != '0) begin
          pop = 1'b1;
          m_valid_n = 1'b1;
          m_n = fifo_q;
          rem_n = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            wcnt_n = '0;
            state_n = WAIT;
          end
        end
      WAIT: begin
        // wcnt is 0 in the cycle the last strobe is visible; ready is stale up to MIN_LAT
        wcnt_n = (wcnt == CW'(TIMEOUT)) ? wcnt : wcnt + CW'(1);
        if (hash_ready && wcnt > CW'(MIN_LAT)) begin
          dig_data_n = digest_final;
          dig_err_n = 1'b0;
          state_n = OUT;
        end else if (wcnt == CW'(TIMEOUT)) begin
          dig_data_n = '0;
          dig_err_n = 1'b1;
          state_n = OUT;
        end
      end
      OUT: state_n = dig_ready ? IDLE : OUT;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      wcnt <= '0;
      C_in <= '0;
      M <= '0;
      M_valid <= 1'b0;
      dig_data <= '0;
      dig_err <= 1'b0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      wcnt <= wcnt_n;
      C_in <= c_in_n;
      M <= m_n;
      M_valid <= m_valid_n;
      dig_data <= dig_data_n;
      dig_err <= dig_err_n;
    end
endmodule

// File: tb/tb_hash_msg_streamer.sv
// tb_hash_msg_streamer: table-driven messages against a behavioural hash core with stale ready
module tb_hash_msg_streamer;
  localparam int MIN_LAT = 2;
  localparam int TIMEOUT = 64;
  localparam int CORE_LAT = 4;
  localparam logic [31:0] H0 = 32'h811C9DC5;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid, cmd_ready, in_valid, in_ready, M_valid, hash_ready, dig_valid, dig_ready, dig_err;
  logic [63:0] cmd_len, C_in;
  logic [7:0] in_data, M;
  logic [31:0] digest_final, dig_data;
  hash_msg_streamer #(.FIFO_DEPTH(4), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .M_valid(M_valid), .C_in(C_in),
    .M(M), .hash_ready(hash_ready), .digest_final(digest_final), .dig_valid(dig_valid),
    .dig_ready(dig_ready), .dig_data(dig_data), .dig_err(dig_err)
  );
  always #5 clk = ~clk;

  typedef struct {int len; int start; int gap; int pre; bit core_en; int hold;} vec_t;
  typedef struct {logic [31:0] data; logic err; int lat;} exp_t;
  int checks = 0, fails = 0;
  exp_t exp_q[$];
  logic [7:0] exp_b[$];
  int cyc = 0, pulses = 0, last_pulse = 0, rise = 0;
  logic [63:0] cur_len = '0;
  logic dv_prev = 1'b0;
  bit core_en = 1'b1;

  function automatic logic [31:0] step(input logic [31:0] h, input logic [7:0] b);
    return (h * 32'd31) ^ {24'd0, b};
  endfunction
  function automatic logic [31:0] fin(input logic [31:0] h, input logic [63:0] n);
    return h ^ n[31:0] ^ 32'hA5A50000;
  endfunction

  // behavioural core: digest after CORE_LAT, old ready lingers 2 cycles into the next message
  logic [31:0] acc, pend;
  logic [63:0] seen;
  int lat, stale;
  bit busy;
  always @(posedge clk or posedge rst)
    if (rst) begin
      hash_ready <= 1'b0; digest_final <= '0; acc <= H0; pend <= '0;
      seen <= '0; lat <= 0; stale <= 0; busy <= 1'b0;
    end else begin
      if (stale > 0) stale <= stale - 1;
      if (stale == 1) hash_ready <= 1'b0;
      if (lat > 0) lat <= lat - 1;
      if (lat == 1 && core_en) begin hash_ready <= 1'b1; digest_final <= pend; end
      if (M_valid) begin
        if (!busy) stale <= 2;
        if (C_in == '0 || seen + 64'd1 == C_in) begin
          pend <= fin((C_in == '0) ? acc : step(acc, M), C_in);
          lat <= CORE_LAT; busy <= 1'b0; seen <= '0; acc <= H0;
        end else begin
          busy <= 1'b1; acc <= step(acc, M); seen <= seen + 64'd1;
        end
      end
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL push_wait: in_ready low for %0d cycles, expected high", t);
      in_valid = 1'b0;
      return;
    end
    exp_b.push_back(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [63:0] len);
    int t = 0;
    cmd_valid = 1'b1; cmd_len = len;
    while (!cmd_ready && t < 300) begin @(posedge clk); #1; t++; end
    chk("cmd_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_msg(input vec_t v, output logic [31:0] got);
    logic [31:0] h = H0;
    exp_t e;
    int t = 0;
    got = '0;
    core_en = v.core_en;
    for (int i = 0; i < v.len; i++) h = step(h, 8'(v.start + i));
    e.data = v.core_en ? fin(h, 64'(v.len)) : '0;
    e.err = !v.core_en;
    e.lat = v.core_en ? CORE_LAT + 2 : TIMEOUT + 1;
    exp_q.push_back(e);
    cur_len = 64'(v.len);
    pulses = 0;
    for (int i = 0; i < v.pre; i++) push_byte(8'(v.start + i));
    fork
      send_cmd(64'(v.len));
      for (int i = v.pre; i < v.len; i++) begin
        push_byte(8'(v.start + i));
        repeat (v.gap) begin @(posedge clk); #1; end
      end
    join
    while (!dig_valid && t < 400) begin @(posedge clk); #1; t++; end
    e = exp_q.pop_front();
    if (!dig_valid) begin
      checks++; fails++;
      $display("FAIL dig_wait: dig_valid low after %0d cycles, len %0d", t, v.len);
      return;
    end
    @(negedge clk); #1;
    got = dig_data;
    chk("dig_data", {32'd0, dig_data}, {32'd0, e.data});
    chk("dig_err", {63'd0, dig_err}, {63'd0, e.err});
    chk("latency", 64'(rise - last_pulse), 64'(e.lat));
    chk("pulses", 64'(pulses), 64'((v.len == 0) ? 1 : v.len));
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, dig_valid}, 64'd1);
      chk("hold_data", {32'd0, dig_data}, {32'd0, e.data});
      chk("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    dig_ready = 1'b1;
    @(posedge clk); #1;
    dig_ready = 1'b0;
    chk("dig_valid_drop", {63'd0, dig_valid}, 64'd0);
    chk("cmd_ready_b2b", {63'd0, cmd_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t post;
    logic [31:0] dg[8];
    int t, b;
    cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0; in_data = '0; dig_ready = 1'b0;
    vecs[0] = '{len:0,   start:0,   gap:0, pre:0, core_en:1'b1, hold:0};
    vecs[1] = '{len:1,   start:65,  gap:0, pre:0, core_en:1'b1, hold:0};
    vecs[2] = '{len:156, start:0,   gap:0, pre:0, core_en:1'b1, hold:0};
    vecs[3] = '{len:156, start:0,   gap:2, pre:0, core_en:1'b1, hold:0};
    vecs[4] = '{len:255, start:0,   gap:0, pre:4, core_en:1'b1, hold:0};
    vecs[5] = '{len:3,   start:7,   gap:0, pre:0, core_en:1'b0, hold:0};
    vecs[6] = '{len:2,   start:200, gap:1, pre:0, core_en:1'b1, hold:10};
    post    = '{len:3,   start:100, gap:0, pre:0, core_en:1'b1, hold:0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_m_valid", {63'd0, M_valid}, 64'd0);
    chk("rst_c_in", C_in, 64'd0);
    chk("rst_m", {56'd0, M}, 64'd0);
    chk("rst_dig_valid", {63'd0, dig_valid}, 64'd0);
    chk("rst_dig_data", {32'd0, dig_data}, 64'd0);
    chk("rst_dig_err", {63'd0, dig_err}, 64'd0);
    rst = 1'b0;
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
          dv_prev = 1'b0;
        end else begin
          if (M_valid) begin
            pulses++;
            last_pulse = cyc;
            chk("c_in", C_in, cur_len);
            if (cur_len == '0) chk("m_empty", {56'd0, M}, 64'd0);
            else if (exp_b.size() == 0) begin
              checks++; fails++;
              $display("FAIL m_extra: strobe with M=%0h, expected no strobe", M);
            end else chk("m_byte", {56'd0, M}, {56'd0, exp_b.pop_front()});
          end
          if (dig_valid && !dv_prev) rise = cyc;
          dv_prev = dig_valid;
        end
      end
    join_none
    for (int i = 0; i < 7; i++) run_msg(vecs[i], dg[i]);
    chk("gap_same_digest", {32'd0, dg[3]}, {32'd0, dg[2]});
    chk("len_changes_digest", {63'd0, dg[4] != dg[2]}, 64'd1);
    cur_len = 64'd400;
    pulses = 0;
    core_en = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'(i));
    send_cmd(64'd400);
    t = 0; b = 4;
    while (pulses < 5 && t < 100) begin push_byte(8'(b)); b++; t++; end
    chk("pulses_before_rst", {63'd0, pulses >= 5}, 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", {63'd0, M_valid}, 64'd0);
    chk("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_c_in", C_in, 64'd0);
    exp_b.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_msg(post, dg[7]);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
